// File: rtl/pc_branch_unit.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pc_branch_unit: flag register, branch resolution, PC ownership, BL link write.
// Rev 1.0
// -----------------------------------------------------------------------------
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [4:0]  LINK_REG = 5'd31,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_i,
  input  logic        is_branch_i,
  input  logic [2:0]  br_op_i,
  input  logic [15:0] imm_off_i,
  input  logic [31:0] reg_target_i,
  input  logic [2:0]  flag_in_i,
  input  logic        flag_we_i,
  input  logic        stall_i,
  input  logic        halt_i,
  output logic [31:0] pc_o,
  output logic [2:0]  flags_o,
  output logic        flush_o,
  output logic        link_we_o,
  output logic [4:0]  link_addr_o,
  output logic [31:0] link_data_o,
  output logic        halted_o,
  output logic        align_err_o
);

  localparam logic [2:0] c_op_b    = 3'b000;
  localparam logic [2:0] c_op_br   = 3'b001;
  localparam logic [2:0] c_op_bltz = 3'b010;
  localparam logic [2:0] c_op_bz   = 3'b011;
  localparam logic [2:0] c_op_bnz  = 3'b100;
  localparam logic [2:0] c_op_bl   = 3'b101;
  localparam logic [2:0] c_op_bcy  = 3'b110;
  localparam logic [2:0] c_op_bncy = 3'b111;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [2:0]  flags_q;
  logic        flush_q;
  logic        link_we_q;
  logic [31:0] link_data_q;
  logic        align_err_q;

  logic [31:0] w_pc_inc;
  logic [31:0] w_rel_target;
  logic [31:0] w_target;
  logic [2:0]  w_eff_flags;
  logic        w_cond;
  logic        w_taken;
  logic        w_is_br;
  logic        w_is_bl;
  logic        w_misalign;
  logic        w_issue;

  assign w_pc_inc     = pc_q + PC_STEP;
  assign w_rel_target = w_pc_inc + {{14{imm_off_i[15]}}, imm_off_i, 2'b00};
  // A flag-writing instruction in the same cycle forwards its flags to the branch.
  assign w_eff_flags  = flag_we_i ? flag_in_i : flags_q;

  always_comb begin
    w_cond = 1'b0;
    case (br_op_i)
      c_op_b:    w_cond = 1'b1;
      c_op_br:   w_cond = 1'b1;
      c_op_bl:   w_cond = 1'b1;
      c_op_bltz: w_cond = w_eff_flags[2];
      c_op_bz:   w_cond = w_eff_flags[1];
      c_op_bnz:  w_cond = ~w_eff_flags[1];
      c_op_bcy:  w_cond = w_eff_flags[0];
      c_op_bncy: w_cond = ~w_eff_flags[0];
      default:   w_cond = 1'b0;
    endcase
  end

  assign w_is_br    = is_branch_i && (br_op_i == c_op_br);
  assign w_is_bl    = is_branch_i && (br_op_i == c_op_bl);
  assign w_taken    = is_branch_i && w_cond;
  assign w_misalign = w_is_br && (reg_target_i[1:0] != 2'b00);
  assign w_target   = w_is_br ? {reg_target_i[31:2], 2'b00} : w_rel_target;
  assign w_issue    = instr_valid_i && !stall_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      flags_q     <= 3'b000;
      flush_q     <= 1'b0;
      link_we_q   <= 1'b0;
      link_data_q <= 32'h0000_0000;
      align_err_q <= 1'b0;
    end else begin
      flush_q   <= 1'b0;
      link_we_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (halt_i) begin
            state_q <= S_HALT;
          end else if (w_issue) begin
            if (flag_we_i) begin
              flags_q <= flag_in_i;
            end
            if (w_taken) begin
              pc_q    <= w_target;
              flush_q <= 1'b1;
              state_q <= S_FLUSH;
            end else begin
              pc_q <= w_pc_inc;
            end
            if (w_is_bl) begin
              link_we_q   <= 1'b1;
              link_data_q <= w_pc_inc;
            end
            if (w_misalign) begin
              align_err_q <= 1'b1;
            end
          end
        end
        // Instructions offered during the bubble are dropped; stall has no effect here.
        S_FLUSH: begin
          state_q <= halt_i ? S_HALT : S_RUN;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_RUN;
        end
      endcase
    end
  end

  assign pc_o        = pc_q;
  assign flags_o     = flags_q;
  assign flush_o     = flush_q;
  assign link_we_o   = link_we_q;
  assign link_addr_o = link_we_q ? LINK_REG : 5'd0;
  assign link_data_o = link_data_q;
  assign halted_o    = (state_q == S_HALT);
  assign align_err_o = align_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_pc_branch_unit: scoreboard bench for pc_branch_unit. Rev 1.0
// -----------------------------------------------------------------------------
module tb_pc_branch_unit;

  localparam logic [2:0] B    = 3'b000;
  localparam logic [2:0] BR   = 3'b001;
  localparam logic [2:0] BLTZ = 3'b010;
  localparam logic [2:0] BZ   = 3'b011;
  localparam logic [2:0] BNZ  = 3'b100;
  localparam logic [2:0] BL   = 3'b101;
  localparam logic [2:0] BCY  = 3'b110;
  localparam logic [2:0] BNCY = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, is_branch, flag_we, stall, halt;
  logic [2:0]  br_op, flag_in;
  logic [15:0] imm_off;
  logic [31:0] reg_target;
  logic [31:0] pc, link_data;
  logic [2:0]  flags;
  logic        flush, link_we, halted, align_err;
  logic [4:0]  link_addr;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       nm;
    logic        rn, iv, br;
    logic [2:0]  op;
    logic [15:0] imm;
    logic [31:0] rt;
    logic [2:0]  fin;
    logic        fwe, st, hl;
    logic [31:0] epc;
    logic [2:0]  efl;
    logic        efs, elw;
    logic [31:0] eld;
    logic        eh, ea;
  } step_t;

  typedef struct {
    string       nm;
    logic [75:0] v;
  } exp_t;

  exp_t sb[$];

  pc_branch_unit #(
    .RESET_PC (32'h0000_0000),
    .LINK_REG (5'd31),
    .PC_STEP  (32'd4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .instr_valid_i (instr_valid),
    .is_branch_i   (is_branch),
    .br_op_i       (br_op),
    .imm_off_i     (imm_off),
    .reg_target_i  (reg_target),
    .flag_in_i     (flag_in),
    .flag_we_i     (flag_we),
    .stall_i       (stall),
    .halt_i        (halt),
    .pc_o          (pc),
    .flags_o       (flags),
    .flush_o       (flush),
    .link_we_o     (link_we),
    .link_addr_o   (link_addr),
    .link_data_o   (link_data),
    .halted_o      (halted),
    .align_err_o   (align_err)
  );

  always #5 clk = ~clk;

  function automatic step_t S(
    input string nm, input logic rn, iv, br, input logic [2:0] op,
    input logic [15:0] imm, input logic [31:0] rt, input logic [2:0] fin,
    input logic fwe, st, hl, input logic [31:0] epc, input logic [2:0] efl,
    input logic efs, elw, input logic [31:0] eld, input logic eh, ea);
    step_t s;
    s.nm = nm; s.rn = rn; s.iv = iv; s.br = br; s.op = op; s.imm = imm;
    s.rt = rt; s.fin = fin; s.fwe = fwe; s.st = st; s.hl = hl;
    s.epc = epc; s.efl = efl; s.efs = efs; s.elw = elw; s.eld = eld;
    s.eh = eh; s.ea = ea;
    return s;
  endfunction

  function automatic logic [75:0] dut_vec();
    return {pc, flags, flush, link_we, link_addr, link_data, halted, align_err};
  endfunction

  task automatic apply(input step_t s);
    exp_t e;
    rst_n = s.rn; instr_valid = s.iv; is_branch = s.br; br_op = s.op;
    imm_off = s.imm; reg_target = s.rt; flag_in = s.fin; flag_we = s.fwe;
    stall = s.st; halt = s.hl;
    e.nm = s.nm;
    // The link register index only appears alongside the BL pulse.
    e.v = {s.epc, s.efl, s.efs, s.elw, (s.elw ? 5'd31 : 5'd0), s.eld, s.eh, s.ea};
    sb.push_back(e);
  endtask

  task automatic test_reset();
    step_t q[$];
    exp_t e;
    q.push_back(S("rst0", 0,0,0,B,16'h0,32'h0,3'b000,0,0,0, 32'h0,3'b000,0,0,32'h0,0,0));
    q.push_back(S("rst1", 0,0,0,B,16'h0,32'h0,3'b000,0,0,0, 32'h0,3'b000,0,0,32'h0,0,0));
    q.push_back(S("idle", 1,0,0,B,16'h0,32'h0,3'b000,0,0,0, 32'h0,3'b000,0,0,32'h0,0,0));
    foreach (q[i]) begin
      apply(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if (dut_vec() !== e.v) begin
        n_err++;
        $display("FAIL reset/%s[%0d]: got %h expected %h", e.nm, i, dut_vec(), e.v);
      end
    end
  endtask

  task automatic test_sequential();
    step_t q[$];
    exp_t e;
    for (int k = 1; k <= 8; k++) begin
      q.push_back(S("seq", 1,1,0,B,16'h0,32'h0,(k == 8) ? 3'b010 : 3'b000,(k == 8),0,0,
                    32'(4 * k),(k == 8) ? 3'b010 : 3'b000,0,0,32'h0,0,0));
    end
    q.push_back(S("noiv_flag", 1,0,0,B,16'h0,32'h0,3'b111,1,0,0, 32'd32,3'b010,0,0,32'h0,0,0));
    foreach (q[i]) begin
      apply(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if (dut_vec() !== e.v) begin
        n_err++;
        $display("FAIL sequential/%s[%0d]: got %h expected %h", e.nm, i, dut_vec(), e.v);
      end
    end
  endtask

  task automatic test_branch_cond();
    step_t q[$];
    exp_t e;
    q.push_back(S("br_100",    1,1,1,BR,  16'h0,   32'h100,3'b000,0,0,0, 32'h100,3'b010,1,0,32'h0,0,0));
    q.push_back(S("bubble",    1,0,0,B,   16'h0,   32'h0,  3'b000,0,0,0, 32'h100,3'b010,0,0,32'h0,0,0));
    q.push_back(S("bz_bypass", 1,1,1,BZ,  16'hFFFE,32'h0,  3'b010,1,0,0, 32'h0FC,3'b010,1,0,32'h0,0,0));
    q.push_back(S("bubble",    1,0,0,B,   16'h0,   32'h0,  3'b000,0,0,0, 32'h0FC,3'b010,0,0,32'h0,0,0));
    q.push_back(S("bz_nt",     1,1,1,BZ,  16'hFFFE,32'h0,  3'b000,1,0,0, 32'h100,3'b000,0,0,32'h0,0,0));
    q.push_back(S("bnz_reg",   1,1,1,BNZ, 16'h0001,32'h0,  3'b111,0,0,0, 32'h108,3'b000,1,0,32'h0,0,0));
    q.push_back(S("drop_fl",   1,1,1,B,   16'h0008,32'h0,  3'b111,1,0,0, 32'h108,3'b000,0,0,32'h0,0,0));
    q.push_back(S("alu_flag",  1,1,0,B,   16'h0,   32'h0,  3'b101,1,0,0, 32'h10C,3'b101,0,0,32'h0,0,0));
    q.push_back(S("bcy_t",     1,1,1,BCY, 16'h0,   32'h0,  3'b000,0,0,0, 32'h110,3'b101,1,0,32'h0,0,0));
    q.push_back(S("bubble",    1,0,0,B,   16'h0,   32'h0,  3'b000,0,0,0, 32'h110,3'b101,0,0,32'h0,0,0));
    q.push_back(S("bncy_nt",   1,1,1,BNCY,16'h0010,32'h0,  3'b000,0,0,0, 32'h114,3'b101,0,0,32'h0,0,0));
    q.push_back(S("bltz_t",    1,1,1,BLTZ,16'h0,   32'h0,  3'b000,0,0,0, 32'h118,3'b101,1,0,32'h0,0,0));
    q.push_back(S("bubble",    1,0,0,B,   16'h0,   32'h0,  3'b000,0,0,0, 32'h118,3'b101,0,0,32'h0,0,0));
    q.push_back(S("bz_reg_nt", 1,1,1,BZ,  16'h0010,32'h0,  3'b000,0,0,0, 32'h11C,3'b101,0,0,32'h0,0,0));
    foreach (q[i]) begin
      apply(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if (dut_vec() !== e.v) begin
        n_err++;
        $display("FAIL branch_cond/%s[%0d]: got %h expected %h", e.nm, i, dut_vec(), e.v);
      end
    end
  endtask

  task automatic test_link_align();
    step_t q[$];
    exp_t e;
    q.push_back(S("br_40",   1,1,1,BR,16'h0,   32'h40, 3'b000,0,0,0, 32'h40, 3'b101,1,0,32'h0, 0,0));
    q.push_back(S("bubble",  1,0,0,B, 16'h0,   32'h0,  3'b000,0,0,0, 32'h40, 3'b101,0,0,32'h0, 0,0));
    q.push_back(S("bl",      1,1,1,BL,16'h0003,32'h0,  3'b000,0,0,0, 32'h50, 3'b101,1,1,32'h44,0,0));
    q.push_back(S("bl_end",  1,0,0,B, 16'h0,   32'h0,  3'b000,0,0,0, 32'h50, 3'b101,0,0,32'h44,0,0));
    q.push_back(S("br_203",  1,1,1,BR,16'h0,   32'h203,3'b000,0,0,0, 32'h200,3'b101,1,0,32'h44,0,1));
    q.push_back(S("bubble",  1,0,0,B, 16'h0,   32'h0,  3'b000,0,0,0, 32'h200,3'b101,0,0,32'h44,0,1));
    q.push_back(S("sticky",  1,1,0,B, 16'h0,   32'h0,  3'b000,0,0,0, 32'h204,3'b101,0,0,32'h44,0,1));
    foreach (q[i]) begin
      apply(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if (dut_vec() !== e.v) begin
        n_err++;
        $display("FAIL link_align/%s[%0d]: got %h expected %h", e.nm, i, dut_vec(), e.v);
      end
    end
  endtask

  task automatic test_stall_halt();
    step_t q[$];
    exp_t e;
    q.push_back(S("stall_b",   1,1,1,B,  16'h0005,32'h0,3'b010,1,1,0, 32'h204,3'b101,0,0,32'h44,0,1));
    q.push_back(S("stall_alu", 1,1,0,B,  16'h0,   32'h0,3'b000,0,1,0, 32'h204,3'b101,0,0,32'h44,0,1));
    q.push_back(S("halt_bcy",  1,1,1,BCY,16'h0004,32'h0,3'b000,0,0,1, 32'h204,3'b101,0,0,32'h44,1,1));
    q.push_back(S("frozen",    1,1,0,B,  16'h0,   32'h0,3'b010,1,0,0, 32'h204,3'b101,0,0,32'h44,1,1));
    q.push_back(S("frozen_bl", 1,1,1,BL, 16'h0,   32'h0,3'b000,0,0,0, 32'h204,3'b101,0,0,32'h44,1,1));
    foreach (q[i]) begin
      apply(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if (dut_vec() !== e.v) begin
        n_err++;
        $display("FAIL stall_halt/%s[%0d]: got %h expected %h", e.nm, i, dut_vec(), e.v);
      end
    end
  endtask

  task automatic test_wrap_reset();
    step_t q[$];
    exp_t e;
    q.push_back(S("rst",      0,0,0,B, 16'h0,   32'h0,        3'b000,0,0,0, 32'h0,        3'b000,0,0,32'h0,0,0));
    q.push_back(S("idle",     1,0,0,B, 16'h0,   32'h0,        3'b000,0,0,0, 32'h0,        3'b000,0,0,32'h0,0,0));
    q.push_back(S("br_top",   1,1,1,BR,16'h0,   32'hFFFF_FFF8,3'b000,0,0,0, 32'hFFFF_FFF8,3'b000,1,0,32'h0,0,0));
    q.push_back(S("bubble",   1,0,0,B, 16'h0,   32'h0,        3'b000,0,0,0, 32'hFFFF_FFF8,3'b000,0,0,32'h0,0,0));
    q.push_back(S("b_wrap",   1,1,1,B, 16'h0002,32'h0,        3'b000,0,0,0, 32'h4,        3'b000,1,0,32'h0,0,0));
    q.push_back(S("rst_fl",   0,1,1,B, 16'h0002,32'h0,        3'b111,1,0,0, 32'h0,        3'b000,0,0,32'h0,0,0));
    q.push_back(S("idle",     1,0,0,B, 16'h0,   32'h0,        3'b000,0,0,0, 32'h0,        3'b000,0,0,32'h0,0,0));
    foreach (q[i]) begin
      apply(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if (dut_vec() !== e.v) begin
        n_err++;
        $display("FAIL wrap_reset/%s[%0d]: got %h expected %h", e.nm, i, dut_vec(), e.v);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t q[$];
    exp_t e;
    q.push_back(S("b_fwd",    1,1,1,B, 16'h0003,32'h0, 3'b000,0,0,0, 32'h10,3'b000,1,0,32'h0,0,0));
    q.push_back(S("bubble",   1,0,0,B, 16'h0,   32'h0, 3'b000,0,0,0, 32'h10,3'b000,0,0,32'h0,0,0));
    q.push_back(S("b_self",   1,1,1,B, 16'hFFFF,32'h0, 3'b000,0,0,0, 32'h10,3'b000,1,0,32'h0,0,0));
    q.push_back(S("bubble",   1,0,0,B, 16'h0,   32'h0, 3'b000,0,0,0, 32'h10,3'b000,0,0,32'h0,0,0));
    q.push_back(S("alu0",     1,1,0,B, 16'h0,   32'h0, 3'b000,0,0,0, 32'h14,3'b000,0,0,32'h0,0,0));
    q.push_back(S("alu1",     1,1,0,B, 16'h0,   32'h0, 3'b000,0,0,0, 32'h18,3'b000,0,0,32'h0,0,0));
    q.push_back(S("br_20",    1,1,1,BR,16'h0,   32'h20,3'b000,0,0,0, 32'h20,3'b000,1,0,32'h0,0,0));
    q.push_back(S("halt_fl",  1,1,1,B, 16'h0004,32'h0, 3'b000,0,1,1, 32'h20,3'b000,0,0,32'h0,1,0));
    q.push_back(S("frozen",   1,1,0,B, 16'h0,   32'h0, 3'b000,0,0,0, 32'h20,3'b000,0,0,32'h0,1,0));
    foreach (q[i]) begin
      apply(q[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if (dut_vec() !== e.v) begin
        n_err++;
        $display("FAIL back_to_back/%s[%0d]: got %h expected %h", e.nm, i, dut_vec(), e.v);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; is_branch = 1'b0; br_op = B;
    imm_off = 16'h0; reg_target = 32'h0; flag_in = 3'b000; flag_we = 1'b0;
    stall = 1'b0; halt = 1'b0;
    test_reset();
    test_sequential();
    test_branch_cond();
    test_link_align();
    test_stall_halt();
    test_wrap_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
